// File: rtl/jcol_sequencer.sv
// Column sequencer: fetches J columns one at a time, evaluates h[c] on the shared
// dot-product tree, streams h out on valid/ready and accumulates the energy term.

module DotProductTree #(
    parameter int N  = 256,
    parameter int W  = 4,
    parameter int RW = W + $clog2(N) + 1
) (
    input  logic [N-1:0]          sigma_i,
    input  logic [N*W-1:0]        j_i,
    output logic signed [RW-1:0]  sum_o
);
    logic signed [RW-1:0] acc;

    // J elements are unsigned, so each term is zero-extended before the signed add/sub.
    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) begin
            if (sigma_i[i]) acc = acc + RW'(j_i[i*W +: W]);
            else            acc = acc - RW'(j_i[i*W +: W]);
        end
        sum_o = acc;
    end
endmodule

// state | meaning
// IDLE  | waiting for start_i
// REQ   | column request held until grant
// WAIT  | granted, waiting for read data
// EMIT  | h[c] presented, waiting for handshake
// DRAIN | aborted with a read in flight, discarding its data
module jcol_sequencer #(
    parameter int VECTOR_SIZE      = 256,
    parameter int J_ELEMENT_WIDTH  = 4,
    parameter int NUM_COLS         = 256,
    parameter int INT_RESULT_WIDTH = J_ELEMENT_WIDTH + $clog2(VECTOR_SIZE) + 1,
    parameter int ENERGY_WIDTH     = INT_RESULT_WIDTH + $clog2(NUM_COLS) + 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  start_i,
    input  logic                                  abort_i,
    input  logic [VECTOR_SIZE-1:0]                sigma_i,
    output logic                                  busy_o,
    output logic                                  mem_req_o,
    output logic [$clog2(NUM_COLS)-1:0]           mem_addr_o,
    input  logic                                  mem_gnt_i,
    input  logic                                  mem_rvalid_i,
    input  logic [VECTOR_SIZE*J_ELEMENT_WIDTH-1:0] mem_rdata_i,
    output logic                                  h_valid_o,
    input  logic                                  h_ready_i,
    output logic signed [INT_RESULT_WIDTH-1:0]    h_data_o,
    output logic [$clog2(NUM_COLS)-1:0]           h_col_o,
    output logic                                  done_o,
    output logic signed [ENERGY_WIDTH-1:0]        energy_o
);
    localparam int CW = $clog2(NUM_COLS);
    localparam int RW = INT_RESULT_WIDTH;
    localparam int EW = ENERGY_WIDTH;
    localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [VECTOR_SIZE-1:0] sigma_q, sigma_d;
    logic [CW-1:0]         col_q, col_d;
    logic signed [RW-1:0]  h_data_q, h_data_d;
    logic [CW-1:0]         h_col_q, h_col_d;
    logic signed [EW-1:0]  acc_q, acc_d;
    logic signed [EW-1:0]  energy_q, energy_d;
    logic                  done_q, done_d;
    logic signed [RW-1:0]  tree_sum;
    logic signed [EW-1:0]  h_signed;

    DotProductTree #(
        .N  (VECTOR_SIZE),
        .W  (J_ELEMENT_WIDTH),
        .RW (RW)
    ) u_tree (
        .sigma_i (sigma_q),
        .j_i     (mem_rdata_i),
        .sum_o   (tree_sum)
    );

    assign h_signed   = sigma_q[col_q] ? EW'(h_data_q) : -EW'(h_data_q);
    assign busy_o     = (state_q != IDLE);
    assign mem_req_o  = (state_q == REQ);
    assign mem_addr_o = col_q;
    // Abort withdraws the result in the same cycle so no handshake can slip through.
    assign h_valid_o  = (state_q == EMIT) && !abort_i;
    assign h_data_o   = h_data_q;
    assign h_col_o    = h_col_q;
    assign done_o     = done_q;
    assign energy_o   = energy_q;

    always_comb begin
        state_d  = state_q;
        sigma_d  = sigma_q;
        col_d    = col_q;
        h_data_d = h_data_q;
        h_col_d  = h_col_q;
        acc_d    = acc_q;
        energy_d = energy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    sigma_d = sigma_i;
                    col_d   = '0;
                    acc_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    if (abort_i) begin
                        state_d = mem_rvalid_i ? IDLE : DRAIN;
                    end else if (mem_rvalid_i) begin
                        h_data_d = tree_sum;
                        h_col_d  = col_q;
                        state_d  = EMIT;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (abort_i) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (abort_i) begin
                    state_d = mem_rvalid_i ? IDLE : DRAIN;
                end else if (mem_rvalid_i) begin
                    h_data_d = tree_sum;
                    h_col_d  = col_q;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (h_ready_i) begin
                    acc_d = acc_q + h_signed;
                    if (col_q == LAST_COL) begin
                        energy_d = acc_d;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = REQ;
                    end
                end
            end
            DRAIN: begin
                if (mem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sigma_q  <= '0;
            col_q    <= '0;
            h_data_q <= '0;
            h_col_q  <= '0;
            acc_q    <= '0;
            energy_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sigma_q  <= sigma_d;
            col_q    <= col_d;
            h_data_q <= h_data_d;
            h_col_q  <= h_col_d;
            acc_q    <= acc_d;
            energy_q <= energy_d;
            done_q   <= done_d;
        end
    end
endmodule
